multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port opcode, input, 7, instruction opcode from the IR; sampled only in DECODE.
REQ-004 SHALL have port zero, input, 1, ALU zero flag; sampled only in BRANCH.
REQ-005 SHALL have port mem_ready, input, 1; memory completes the current request in the cycle it is 1.
REQ-006 SHALL have port mem_req, output, 1, memory access request.
REQ-007 SHALL have port adr_src, output, 1; 0 = PC, 1 = ALU out.
REQ-008 SHALL have ports pc_write, ir_write, mem_write, reg_write, output, 1 each; write strobes.
REQ-009 SHALL have port alu_src_a, output, 2; 00 PC, 01 old PC, 10 rs1.
REQ-010 SHALL have port alu_src_b, output, 2; 00 rs2, 01 immediate, 10 constant 4.
REQ-011 SHALL have port result_src, output, 2; 00 ALU out register, 01 memory data, 10 ALU result.
REQ-012 SHALL have port alu_op, output, 2; 00 add, 01 subtract, 10 funct-decoded.
REQ-013 SHALL have ports instr_done and illegal_op, output, 1 each; single-cycle pulses.

Function
REQ-014 SHALL implement Moore FSM states FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JUMP.
REQ-015 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10; stay while mem_ready=0; when mem_ready=1, pulse ir_write and pc_write and go to DECODE.
REQ-016 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target); next state by opcode: 0000011/0100011 -> MEM_ADR, 0110011 -> EXEC_R, 0010011 -> EXEC_I, 1100011 -> BRANCH, 1100111/1101111 -> JUMP.
REQ-017 DECODE with any other opcode SHALL pulse illegal_op and return to FETCH with no write strobe asserted.
REQ-018 MEM_ADR: alu_src_a=10, alu_src_b=01, alu_op=00; -> MEM_READ for load, MEM_WRITE for store (opcode latched in DECODE).
REQ-019 MEM_READ: mem_req=1, adr_src=1; wait for mem_ready, then -> MEM_WB.
REQ-020 MEM_WRITE: mem_req=1, adr_src=1, mem_write=1 only in the cycle mem_ready=1; then pulse instr_done and -> FETCH.
REQ-021 MEM_WB: result_src=01, reg_write=1, instr_done=1; -> FETCH.
REQ-022 EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10; EXEC_I: alu_src_a=10, alu_src_b=01, alu_op=10; both -> ALU_WB.
REQ-023 ALU_WB: result_src=00, reg_write=1, instr_done=1; -> FETCH.
REQ-024 BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00; pc_write = zero; instr_done=1; -> FETCH.
REQ-025 JUMP: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1; -> ALU_WB (link write).
REQ-026 Strobes not listed for a state SHALL be 0; mux selects not listed SHALL be 00.
REQ-027 With mem_ready held 1, cycles per instruction SHALL be: R/I 4, load 5, store 4, beq 3, jump 4; each extra mem_ready=0 cycle adds exactly one cycle.
REQ-028 mem_req SHALL stay 1 and the address select stable for every wait cycle of a memory state.

Reset
REQ-029 While reset=1 the FSM SHALL be forced to FETCH and all strobes (pc_write, ir_write, mem_write, reg_write, mem_req, instr_done, illegal_op) SHALL be 0; selects 00.
REQ-030 Reset asserted mid-instruction (including during a memory wait) SHALL abort it; first cycle after reset deassertion is FETCH with mem_req=1.

Structure
REQ-031 Package mc_pkg SHALL hold the state enum, opcode constants, and encodings for alu_src_a/b, result_src, alu_op.
REQ-032 Opcode classification SHALL live in one combinational sub-module op_class_decode; the FSM stays in multicycle_control.

Verification
REQ-033 Reset mid-MEM_READ wait -> next cycle state FETCH, mem_write=reg_write=0, then mem_req=1 after release.
REQ-034 opcode=0110011, mem_ready=1 -> ir_write at cycle 1, reg_write with result_src=00 at cycle 4, instr_done at cycle 4.
REQ-035 opcode=0000011, mem_ready low 3 cycles in MEM_READ -> reg_write with result_src=01 at cycle 8.
REQ-036 opcode=1100011 with zero=1 then zero=0 -> pc_write=1 then 0 in BRANCH, 3 cycles each.
REQ-037 opcode=0100011 -> mem_write=1 exactly one cycle, coincident with mem_ready=1, reg_write never 1.
REQ-038 opcode=1111111 -> illegal_op pulse in DECODE, FETCH next cycle, no write strobe.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states,
// opcode constants, opcode classes and datapath select encodings.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEM_ADR,
      S_MEM_READ,
      S_MEM_WB,
      S_MEM_WRITE,
      S_EXEC_R,
      S_EXEC_I,
      S_ALU_WB,
      S_BRANCH,
      S_JUMP
   } state_e;

   typedef enum logic [2:0] {
      CL_LOAD,
      CL_STORE,
      CL_R,
      CL_I,
      CL_BRANCH,
      CL_JUMP,
      CL_ILLEGAL
   } op_class_e;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      SRCA_PC     = 2'b00,
      SRCA_OLD_PC = 2'b01,
      SRCA_RS1    = 2'b10
   } alu_src_a_e;

   typedef enum logic [1:0] {
      SRCB_RS2   = 2'b00,
      SRCB_IMM   = 2'b01,
      SRCB_FOUR  = 2'b10
   } alu_src_b_e;

   typedef enum logic [1:0] {
      RES_ALU_OUT = 2'b00,
      RES_MEM     = 2'b01,
      RES_ALU     = 2'b10
   } result_src_e;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_e;

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control unit and the datapath/memory: instruction
// status inputs plus every strobe and mux select the controller drives.
interface multicycle_control_if;

   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;

   logic       mem_req;
   logic       adr_src;
   logic       pc_write;
   logic       ir_write;
   logic       mem_write;
   logic       reg_write;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic [1:0] alu_op;
   logic       instr_done;
   logic       illegal_op;

   // Controller side
   modport master (
      input  opcode, zero, mem_ready,
      output mem_req, adr_src, pc_write, ir_write, mem_write, reg_write,
             alu_src_a, alu_src_b, result_src, alu_op, instr_done, illegal_op
   );

   // Datapath / memory side
   modport slave (
      output opcode, zero, mem_ready,
      input  mem_req, adr_src, pc_write, ir_write, mem_write, reg_write,
             alu_src_a, alu_src_b, result_src, alu_op, instr_done, illegal_op
   );

endinterface

// File: rtl/multicycle_control_op_class.sv
// Opcode classifier: maps a raw 7-bit opcode onto the instruction class
// that steers the control FSM out of DECODE.
module op_class_decode
   import mc_pkg::*;
(
   input  logic [6:0] opcode_i,
   output op_class_e  op_class_o
);

   // Pure lookup; anything unrecognised is illegal
   always_comb begin
      op_class_o = CL_ILLEGAL;
      case (opcode_i)
         OP_LOAD:          op_class_o = CL_LOAD;
         OP_STORE:         op_class_o = CL_STORE;
         OP_R:             op_class_o = CL_R;
         OP_I:             op_class_o = CL_I;
         OP_BRANCH:        op_class_o = CL_BRANCH;
         OP_JALR, OP_JAL:  op_class_o = CL_JUMP;
         default:          op_class_o = CL_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control FSM. Sequences fetch, decode, memory access,
// execute and write-back, stalling in memory states until mem_ready.
module multicycle_control
   import mc_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   multicycle_control_if.master bus
);

   state_e    state_q, state_d;
   op_class_e class_q, class_d;
   op_class_e dec_class;

   op_class_decode u_op_class_decode (
      .opcode_i   (bus.opcode),
      .op_class_o (dec_class)
   );

   // State register plus the instruction class captured in DECODE
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q <= S_FETCH;
         class_q <= CL_ILLEGAL;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
      end
   end

   // Next state and all strobes/selects; outputs held inactive during reset
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      state_d        = state_q;
      class_d        = class_q;
      bus.mem_req    = 1'b0;
      bus.adr_src    = 1'b0;
      bus.pc_write   = 1'b0;
      bus.ir_write   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.reg_write  = 1'b0;
      bus.instr_done = 1'b0;
      bus.illegal_op = 1'b0;
      bus.alu_src_a  = SRCA_PC;
      bus.alu_src_b  = SRCB_RS2;
      bus.result_src = RES_ALU_OUT;
      bus.alu_op     = ALU_ADD;

      if (!reset) begin
         unique case (state_q)
            S_FETCH: begin
               bus.mem_req    = 1'b1;
               bus.alu_src_b  = SRCB_FOUR;
               bus.result_src = RES_ALU;
               if (bus.mem_ready) begin
                  bus.ir_write = 1'b1;
                  bus.pc_write = 1'b1;
                  state_d      = S_DECODE;
               end
            end
            S_DECODE: begin
               bus.alu_src_a = SRCA_OLD_PC;
               bus.alu_src_b = SRCB_IMM;
               class_d       = dec_class;
               case (dec_class)
                  CL_LOAD, CL_STORE: state_d = S_MEM_ADR;
                  CL_R:              state_d = S_EXEC_R;
                  CL_I:              state_d = S_EXEC_I;
                  CL_BRANCH:         state_d = S_BRANCH;
                  CL_JUMP:           state_d = S_JUMP;
                  default: begin
                     bus.illegal_op = 1'b1;
                     state_d        = S_FETCH;
                  end
               endcase
            end
            S_MEM_ADR: begin
               bus.alu_src_a = SRCA_RS1;
               bus.alu_src_b = SRCB_IMM;
               state_d       = (class_q == CL_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
               bus.mem_req = 1'b1;
               bus.adr_src = 1'b1;
               if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WRITE: begin
               bus.mem_req = 1'b1;
               bus.adr_src = 1'b1;
               if (bus.mem_ready) begin
                  bus.mem_write  = 1'b1;
                  bus.instr_done = 1'b1;
                  state_d        = S_FETCH;
               end
            end
            S_MEM_WB: begin
               bus.result_src = RES_MEM;
               bus.reg_write  = 1'b1;
               bus.instr_done = 1'b1;
               state_d        = S_FETCH;
            end
            S_EXEC_R: begin
               bus.alu_src_a = SRCA_RS1;
               bus.alu_src_b = SRCB_RS2;
               bus.alu_op    = ALU_FUNCT;
               state_d       = S_ALU_WB;
            end
            S_EXEC_I: begin
               bus.alu_src_a = SRCA_RS1;
               bus.alu_src_b = SRCB_IMM;
               bus.alu_op    = ALU_FUNCT;
               state_d       = S_ALU_WB;
            end
            S_ALU_WB: begin
               bus.result_src = RES_ALU_OUT;
               bus.reg_write  = 1'b1;
               bus.instr_done = 1'b1;
               state_d        = S_FETCH;
            end
            S_BRANCH: begin
               bus.alu_src_a  = SRCA_RS1;
               bus.alu_src_b  = SRCB_RS2;
               bus.alu_op     = ALU_SUB;
               bus.pc_write   = bus.zero;
               bus.instr_done = 1'b1;
               state_d        = S_FETCH;
            end
            S_JUMP: begin
               bus.alu_src_a = SRCA_OLD_PC;
               bus.alu_src_b = SRCB_FOUR;
               bus.pc_write  = 1'b1;
               state_d       = S_ALU_WB;
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is expanded
// from its opcode into the per-cycle output bundles the control unit must
// present; a single compare process checks every cycle, and per-instruction
// timing facts observed on the DUT are pinned against hand-computed values.
module tb_multicycle_control;

   typedef struct packed {
      logic       mem_req;
      logic       adr_src;
      logic       pc_write;
      logic       ir_write;
      logic       mem_write;
      logic       reg_write;
      logic       instr_done;
      logic       illegal_op;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [1:0] res_src;
      logic [1:0] alu_op;
   } out_t;

   localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3, K_BR = 4, K_JUMP = 5, K_ILL = 6;

   logic clk = 1'b0;
   logic reset;

   multicycle_control_if bus ();

   multicycle_control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   out_t  exp_o;
   out_t  act;
   logic  exp_vld = 1'b0;
   int    cyc;
   string tag;

   // Observed per-instruction facts (cycle numbers start at 1 with the first FETCH cycle)
   int    ir_cyc, rw_cyc, done_cyc, ill_cyc, rw_cnt, mw_cnt, mw_no_rdy;
   logic  pcw3;

   assign act = '{bus.mem_req, bus.adr_src, bus.pc_write, bus.ir_write, bus.mem_write,
                  bus.reg_write, bus.instr_done, bus.illegal_op, bus.alu_src_a,
                  bus.alu_src_b, bus.result_src, bus.alu_op};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Compare process: every cycle with a valid expectation, mid-cycle
   always @(negedge clk) begin
      if (exp_vld) begin
         check($sformatf("%s cyc%0d outputs", tag, cyc), 32'(act), 32'(exp_o));
         if (act.ir_write && ir_cyc < 0) ir_cyc = cyc;
         if (act.reg_write) begin
            rw_cnt++;
            rw_cyc = cyc;
         end
         if (act.mem_write) begin
            mw_cnt++;
            if (!bus.mem_ready) mw_no_rdy++;
         end
         if (act.instr_done) done_cyc = cyc;
         if (act.illegal_op) ill_cyc = cyc;
         if (cyc == 3) pcw3 = act.pc_write;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic int kind_of(input logic [6:0] opc);
      case (opc)
         7'b0000011:             return K_LOAD;
         7'b0100011:             return K_STORE;
         7'b0110011:             return K_R;
         7'b0010011:             return K_I;
         7'b1100011:             return K_BR;
         7'b1100111, 7'b1101111: return K_JUMP;
         default:                return K_ILL;
      endcase
   endfunction

   function automatic out_t fetch_o(input logic rdy);
      out_t e = '0;
      e.mem_req  = 1'b1;
      e.src_b    = 2'b10;
      e.res_src  = 2'b10;
      e.ir_write = rdy;
      e.pc_write = rdy;
      return e;
   endfunction

   function automatic out_t mem_o(input logic wr);
      out_t e = '0;
      e.mem_req    = 1'b1;
      e.adr_src    = 1'b1;
      e.mem_write  = wr;
      e.instr_done = wr;
      return e;
   endfunction

   function automatic out_t wb_o(input logic [1:0] res);
      out_t e = '0;
      e.res_src    = res;
      e.reg_write  = 1'b1;
      e.instr_done = 1'b1;
      return e;
   endfunction

   function automatic out_t alu_o(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
      out_t e = '0;
      e.src_a  = a;
      e.src_b  = b;
      e.alu_op = op;
      return e;
   endfunction

   // One clock cycle: drive inputs and publish what the outputs must be
   task automatic step(input logic rdy, input logic z, input out_t e);
      bus.mem_ready = rdy;
      bus.zero      = z;
      exp_o         = e;
      exp_vld       = 1'b1;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats(input string name);
      tag       = name;
      cyc       = 0;
      ir_cyc    = -1;
      rw_cyc    = -1;
      done_cyc  = -1;
      ill_cyc   = -1;
      rw_cnt    = 0;
      mw_cnt    = 0;
      mw_no_rdy = 0;
      pcw3      = 1'bx;
   endtask

   // Expand one instruction into its cycle sequence with the given wait counts
   task automatic run_instr(input string name, input logic [6:0] opc, input logic z,
                            input int fw, input int mw);
      int   k;
      out_t e;
      k = kind_of(opc);
      clear_stats(name);
      bus.opcode = opc;
      repeat (fw) step(1'b0, rb(), fetch_o(1'b0));
      step(1'b1, rb(), fetch_o(1'b1));
      e = alu_o(2'b01, 2'b01, 2'b00);
      e.illegal_op = (k == K_ILL);
      step(rb(), rb(), e);
      // Opcode only matters in DECODE; scramble it afterwards
      bus.opcode = 7'($urandom);
      case (k)
         K_LOAD: begin
            step(rb(), rb(), alu_o(2'b10, 2'b01, 2'b00));
            repeat (mw) step(1'b0, rb(), mem_o(1'b0));
            step(1'b1, rb(), mem_o(1'b0));
            step(rb(), rb(), wb_o(2'b01));
         end
         K_STORE: begin
            step(rb(), rb(), alu_o(2'b10, 2'b01, 2'b00));
            repeat (mw) step(1'b0, rb(), mem_o(1'b0));
            step(1'b1, rb(), mem_o(1'b1));
         end
         K_R: begin
            step(rb(), rb(), alu_o(2'b10, 2'b00, 2'b10));
            step(rb(), rb(), wb_o(2'b00));
         end
         K_I: begin
            step(rb(), rb(), alu_o(2'b10, 2'b01, 2'b10));
            step(rb(), rb(), wb_o(2'b00));
         end
         K_BR: begin
            e = alu_o(2'b10, 2'b00, 2'b01);
            e.pc_write   = z;
            e.instr_done = 1'b1;
            step(rb(), z, e);
         end
         K_JUMP: begin
            e = alu_o(2'b01, 2'b10, 2'b00);
            e.pc_write = 1'b1;
            step(rb(), rb(), e);
            step(rb(), rb(), wb_o(2'b00));
         end
         default: ;
      endcase
   endtask

   initial begin
      reset         = 1'b1;
      bus.opcode    = 7'b0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;
      clear_stats("reset");
      @(posedge clk);
      #1;
      repeat (3) step(rb(), rb(), '0);
      reset = 1'b0;

      // R-type, no waits: ir_write at 1, reg_write and done at 4
      run_instr("r_type", 7'b0110011, 1'b0, 0, 0);
      check("r ir_write cycle", 32'(ir_cyc), 32'd1);
      check("r reg_write cycle", 32'(rw_cyc), 32'd4);
      check("r done cycle", 32'(done_cyc), 32'd4);

      // I-type with one fetch wait: 4 + 1
      run_instr("i_type", 7'b0010011, 1'b0, 1, 0);
      check("i done cycle", 32'(done_cyc), 32'd5);

      // Load with three read waits: reg_write at 8
      run_instr("load_w3", 7'b0000011, 1'b0, 0, 3);
      check("load_w3 reg_write cycle", 32'(rw_cyc), 32'd8);
      check("load_w3 done cycle", 32'(done_cyc), 32'd8);

      run_instr("load", 7'b0000011, 1'b0, 0, 0);
      check("load done cycle", 32'(done_cyc), 32'd5);

      // Store: exactly one mem_write, only with mem_ready, never reg_write
      run_instr("store", 7'b0100011, 1'b0, 0, 0);
      check("store mem_write count", 32'(mw_cnt), 32'd1);
      check("store mem_write w/o ready", 32'(mw_no_rdy), 32'd0);
      check("store reg_write count", 32'(rw_cnt), 32'd0);
      check("store done cycle", 32'(done_cyc), 32'd4);

      run_instr("store_w2", 7'b0100011, 1'b0, 0, 2);
      check("store_w2 mem_write count", 32'(mw_cnt), 32'd1);
      check("store_w2 done cycle", 32'(done_cyc), 32'd6);

      // Branch taken / not taken
      run_instr("beq_taken", 7'b1100011, 1'b1, 0, 0);
      check("beq_taken pc_write", 32'(pcw3), 32'd1);
      check("beq_taken done cycle", 32'(done_cyc), 32'd3);
      run_instr("beq_not", 7'b1100011, 1'b0, 0, 0);
      check("beq_not pc_write", 32'(pcw3), 32'd0);
      check("beq_not done cycle", 32'(done_cyc), 32'd3);

      // Jumps
      run_instr("jal", 7'b1101111, 1'b0, 0, 0);
      check("jal done cycle", 32'(done_cyc), 32'd4);
      run_instr("jalr_fw2", 7'b1100111, 1'b0, 2, 0);
      check("jalr_fw2 done cycle", 32'(done_cyc), 32'd6);

      // Illegal opcodes: pulse in DECODE, straight back to FETCH
      run_instr("illegal_ff", 7'b1111111, 1'b0, 0, 0);
      check("illegal pulse cycle", 32'(ill_cyc), 32'd2);
      check("illegal reg_write count", 32'(rw_cnt), 32'd0);
      check("illegal done cycle", 32'(done_cyc), 32'hffffffff);
      run_instr("illegal_00", 7'b0000000, 1'b0, 0, 0);
      check("illegal_00 pulse cycle", 32'(ill_cyc), 32'd2);

      // Reset during a MEM_READ wait aborts the load
      clear_stats("abort");
      bus.opcode = 7'b0000011;
      step(1'b1, rb(), fetch_o(1'b1));
      step(rb(), rb(), alu_o(2'b01, 2'b01, 2'b00));
      bus.opcode = 7'($urandom);
      step(rb(), rb(), alu_o(2'b10, 2'b01, 2'b00));
      step(1'b0, rb(), mem_o(1'b0));
      step(1'b0, rb(), mem_o(1'b0));
      reset = 1'b1;
      step(1'b0, rb(), '0);
      reset = 1'b0;
      check("abort reg_write count", 32'(rw_cnt), 32'd0);
      check("abort mem_write count", 32'(mw_cnt), 32'd0);
      run_instr("after_abort", 7'b0110011, 1'b0, 0, 0);
      check("after_abort ir_write cycle", 32'(ir_cyc), 32'd1);
      check("after_abort done cycle", 32'(done_cyc), 32'd4);

      exp_vld = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
